// File: rtl/gemcsc_match_sequencer.sv
// ============================================================================
// Module   : gemcsc_match_sequencer
// Purpose  : Match-window sequencer feeding the GEM-CSC LCT quality encoder.
//            Optional macro GEMCSC_EARLY_CLOSE_EN closes the window as soon as
//            ALCT, CLCT and copad have all been seen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemcsc_match_sequencer #(
    parameter int WIN_BITS      = 3,
    parameter int DEAD_BITS     = 4,
    parameter int LCT_CNT_BITS  = 16,
    parameter int DROP_CNT_BITS = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     alct_vpf,
    input  logic                     clct_vpf,
    input  logic                     gem_vpf,
    input  logic                     copad_vpf,
    input  logic                     clct_bend_ok,
    input  logic [WIN_BITS-1:0]      cfg_match_win,
    input  logic [DEAD_BITS-1:0]     cfg_dead_time,
    input  logic                     cfg_bend_en,
    output logic                     lct_vpf,
    output logic                     alct_clct_copad_match,
    output logic                     alct_clct_gem_match,
    output logic                     alct_clct_match,
    output logic                     clct_copad_match,
    output logic                     alct_copad_match,
    output logic                     gemcsc_bend_enable,
    output logic                     busy,
    output logic [LCT_CNT_BITS-1:0]  lct_count,
    output logic [DROP_CNT_BITS-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        EMIT   = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [WIN_BITS-1:0]      cnt_q, cnt_d;
    logic [DEAD_BITS-1:0]     dcnt_q, dcnt_d;
    logic                     sa_q, sc_q, sg_q, sp_q, sb_q;
    logic                     sa_d, sc_d, sg_d, sp_d, sb_d;
    logic [6:0]               out_q, out_d;
    logic [LCT_CNT_BITS-1:0]  lct_cnt_q, lct_cnt_d;
    logic [DROP_CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

    logic                     w_trig;
    logic                     w_drop;
    logic                     w_close;
    logic [WIN_BITS-1:0]      w_win;
    logic [5:0]               w_flags;

    assign w_trig = alct_vpf | clct_vpf;
    assign w_win  = (cfg_match_win == '0) ? WIN_BITS'(1) : cfg_match_win;

`ifdef GEMCSC_EARLY_CLOSE_EN
    assign w_close = sa_d & sc_d & sp_d;
`else
    assign w_close = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        sa_d       = sa_q;
        sc_d       = sc_q;
        sg_d       = sg_q;
        sp_d       = sp_q;
        sb_d       = sb_q;
        w_drop     = 1'b0;
        out_d      = '0;
        w_flags    = '0;
        lct_cnt_d  = lct_cnt_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (w_trig) begin
                    sa_d  = alct_vpf;
                    sc_d  = clct_vpf;
                    sg_d  = gem_vpf;
                    sp_d  = copad_vpf;
                    sb_d  = clct_vpf & clct_bend_ok;
                    cnt_d = WIN_BITS'(1);
                    state_d = (w_win == WIN_BITS'(1) || w_close) ? EMIT : WINDOW;
                end
            end
            WINDOW: begin
                sa_d   = sa_q | alct_vpf;
                sc_d   = sc_q | clct_vpf;
                sg_d   = sg_q | gem_vpf;
                sp_d   = sp_q | copad_vpf;
                sb_d   = sb_q | (clct_vpf & clct_bend_ok);
                w_drop = (alct_vpf & sa_q) | (clct_vpf & sc_q);
                // cnt counts window cycles already spent; the current one is cnt+1.
                if (cnt_q >= w_win - WIN_BITS'(1) || w_close) begin
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + WIN_BITS'(1);
                end
            end
            EMIT: begin
                w_drop  = w_trig;
                dcnt_d  = DEAD_BITS'(1);
                state_d = (out_q[6] && cfg_dead_time != '0) ? DEAD : IDLE;
            end
            DEAD: begin
                w_drop = w_trig;
                if (dcnt_q >= cfg_dead_time) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + DEAD_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags are registered on the way into EMIT so they are visible in the EMIT cycle.
        if (state_d == EMIT) begin
            w_flags[5] = sa_d & sc_d & sp_d;
            w_flags[4] = sa_d & sc_d & sg_d & ~sp_d;
            w_flags[3] = sa_d & sc_d & ~sg_d & ~sp_d;
            w_flags[2] = sc_d & ~sa_d & sp_d;
            w_flags[1] = sa_d & ~sc_d & sp_d;
            w_flags[0] = cfg_bend_en & sb_d;
            out_d      = {|w_flags[5:1], w_flags};
            if (out_d[6] && lct_cnt_q != '1) begin
                lct_cnt_d = lct_cnt_q + LCT_CNT_BITS'(1);
            end
        end

        if (w_drop && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            sa_q       <= 1'b0;
            sc_q       <= 1'b0;
            sg_q       <= 1'b0;
            sp_q       <= 1'b0;
            sb_q       <= 1'b0;
            out_q      <= '0;
            lct_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            sa_q       <= sa_d;
            sc_q       <= sc_d;
            sg_q       <= sg_d;
            sp_q       <= sp_d;
            sb_q       <= sb_d;
            out_q      <= out_d;
            lct_cnt_q  <= lct_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign lct_vpf               = out_q[6];
    assign alct_clct_copad_match = out_q[5];
    assign alct_clct_gem_match   = out_q[4];
    assign alct_clct_match       = out_q[3];
    assign clct_copad_match      = out_q[2];
    assign alct_copad_match      = out_q[1];
    assign gemcsc_bend_enable    = out_q[0];
    assign busy                  = (state_q != IDLE);
    assign lct_count             = lct_cnt_q;
    assign drop_count            = drop_cnt_q;

endmodule

`default_nettype wire
